// File: rtl/control_fsm.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, address,
// load/store and trap states driving datapath selects and strobes.
// Ports: clk/rst_n; ir, br_eq, br_lt, mem_resp in; aluop, alumux1_sel,
// alumux2_sel, cmp_unsigned, load_ir, load_pc, load_mar, regfile_we,
// mem_read, mem_write, pcmux_sel, regfilemux_sel, mem_size, illegal out.
module control_fsm #(
  parameter int OP_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         ir,
  input  logic                br_eq,
  input  logic                br_lt,
  input  logic                mem_resp,
  output logic [OP_WIDTH-1:0] aluop,
  output logic                alumux1_sel,
  output logic [1:0]          alumux2_sel,
  output logic                cmp_unsigned,
  output logic                load_ir,
  output logic                load_pc,
  output logic                load_mar,
  output logic                regfile_we,
  output logic                mem_read,
  output logic                mem_write,
  output logic                pcmux_sel,
  output logic [1:0]          regfilemux_sel,
  output logic [1:0]          mem_size,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_ADDR,
    S_LOAD,
    S_STORE,
    S_TRAP
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [OP_WIDTH-1:0] ALU_JALR = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] ALU_ADD  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] ALU_SUB  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] ALU_AND  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] ALU_OR   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] ALU_XOR  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] ALU_SLL  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] ALU_SRL  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] ALU_SRA  = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] ALU_LUI  = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] ALU_SLT0 = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] ALU_SLT1 = OP_WIDTH'(11);

  state_e state_q, state_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b;
  logic       unused_ir;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7b = ir[30];

  // Register/immediate fields are consumed by the datapath, not here.
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  logic is_op, is_opi, is_lui, is_auipc;
  logic is_jal, is_jalr, is_br, is_ld, is_st;
  logic br_bad;
  logic taken;

  assign is_op    = (opc == OPC_OP);
  assign is_opi   = (opc == OPC_OPIMM);
  assign is_lui   = (opc == OPC_LUI);
  assign is_auipc = (opc == OPC_AUIPC);
  assign is_jal   = (opc == OPC_JAL);
  assign is_jalr  = (opc == OPC_JALR);
  assign is_br    = (opc == OPC_BRANCH);
  assign is_ld    = (opc == OPC_LOAD);
  assign is_st    = (opc == OPC_STORE);

  // funct3 010/011 are unused encodings in the branch space.
  assign br_bad = (f3 == 3'b010) || (f3 == 3'b011);

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = br_eq;
      3'b001:  taken = ~br_eq;
      3'b100:  taken = br_lt;
      3'b101:  taken = ~br_lt;
      3'b110:  taken = br_lt;
      3'b111:  taken = ~br_lt;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    aluop          = ALU_ADD;
    alumux1_sel    = 1'b0;
    alumux2_sel    = 2'd0;
    cmp_unsigned   = 1'b0;
    load_ir        = 1'b0;
    load_pc        = 1'b0;
    load_mar       = 1'b0;
    regfile_we     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    pcmux_sel      = 1'b0;
    regfilemux_sel = 2'd0;
    mem_size       = 2'd2;
    illegal        = 1'b0;

    // Gating on rst_n kills any memory request the instant reset lands.
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_resp) begin
            load_ir = 1'b1;
            state_d = S_DECODE;
          end
        end

        S_DECODE: begin
          unique case (1'b1)
            is_op, is_opi, is_lui, is_auipc,
            is_jal, is_jalr: state_d = S_EXECUTE;
            is_br:   state_d = br_bad ? S_TRAP : S_EXECUTE;
            is_ld, is_st: state_d = S_ADDR;
            default: state_d = S_TRAP;
          endcase
        end

        S_EXECUTE: begin
          load_pc = 1'b1;
          state_d = S_FETCH;
          unique case (1'b1)
            is_op, is_opi: begin
              regfile_we  = 1'b1;
              alumux2_sel = is_op ? 2'd0 : 2'd1;
              unique case (f3)
                3'b000: aluop = (is_op && f7b) ? ALU_SUB
                                               : ALU_ADD;
                3'b111: aluop = ALU_AND;
                3'b110: aluop = ALU_OR;
                3'b100: aluop = ALU_XOR;
                3'b001: aluop = ALU_SLL;
                3'b101: aluop = f7b ? ALU_SRA : ALU_SRL;
                3'b010: aluop = br_lt ? ALU_SLT1 : ALU_SLT0;
                3'b011: begin
                  aluop        = br_lt ? ALU_SLT1 : ALU_SLT0;
                  cmp_unsigned = 1'b1;
                end
              endcase
            end
            is_lui: begin
              aluop       = ALU_LUI;
              alumux2_sel = 2'd3;
              regfile_we  = 1'b1;
            end
            is_auipc: begin
              alumux1_sel = 1'b1;
              alumux2_sel = 2'd3;
              regfile_we  = 1'b1;
            end
            is_jal: begin
              alumux1_sel    = 1'b1;
              alumux2_sel    = 2'd3;
              pcmux_sel      = 1'b1;
              regfile_we     = 1'b1;
              regfilemux_sel = 2'd1;
            end
            is_jalr: begin
              aluop          = ALU_JALR;
              alumux2_sel    = 2'd1;
              pcmux_sel      = 1'b1;
              regfile_we     = 1'b1;
              regfilemux_sel = 2'd1;
            end
            is_br: begin
              alumux1_sel  = 1'b1;
              alumux2_sel  = 2'd3;
              cmp_unsigned = f3[2] & f3[1];
              pcmux_sel    = taken;
            end
            default: ;
          endcase
        end

        S_ADDR: begin
          load_mar    = 1'b1;
          alumux2_sel = is_st ? 2'd2 : 2'd1;
          state_d     = is_st ? S_STORE : S_LOAD;
        end

        S_LOAD: begin
          mem_read = 1'b1;
          mem_size = f3[1:0];
          if (mem_resp) begin
            regfile_we     = 1'b1;
            regfilemux_sel = 2'd2;
            load_pc        = 1'b1;
            state_d        = S_FETCH;
          end
        end

        S_STORE: begin
          mem_write = 1'b1;
          mem_size  = f3[1:0];
          if (mem_resp) begin
            load_pc = 1'b1;
            state_d = S_FETCH;
          end
        end

        S_TRAP: begin
          illegal = 1'b1;
        end

        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 4: width of aluop.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ir  in  32  latched instruction (opcode [6:0], funct3 [14:12], funct7 bit 30).
REQ-005 SHALL have port br_eq, br_lt  in  1 each  comparator results for rs1 vs rs2 (br_lt honours cmp_unsigned).
REQ-006 SHALL have port mem_resp  in  1  memory completion strobe, one cycle.
REQ-007 SHALL have port aluop  out  OP_WIDTH  ALU operation code.
REQ-008 SHALL have port alumux1_sel  out  1  0=rs1, 1=pc.
REQ-009 SHALL have port alumux2_sel  out  2  0=rs2, 1=I-imm, 2=S-imm, 3=U/J/B-imm per opcode.
REQ-010 SHALL have port cmp_unsigned  out  1  comparator unsigned mode.
REQ-011 SHALL have ports load_ir, load_pc, load_mar, regfile_we, mem_read, mem_write  out  1 each  strobes.
REQ-012 SHALL have port pcmux_sel  out  1  0=pc+4, 1=aluout.
REQ-013 SHALL have port regfilemux_sel  out  2  0=aluout, 1=pc+4, 2=load data.
REQ-014 SHALL have port mem_size  out  2  0=byte, 1=half, 2=word.
REQ-015 SHALL have port illegal  out  1  sticky illegal-instruction flag.

Function
REQ-016 SHALL implement states FETCH, DECODE, EXECUTE, ADDR, LOAD, STORE, TRAP; outputs Moore per state except where stated.
REQ-017 FETCH: mem_read=1, mem_size=2, alumux/aluop don't-care; mem_resp -> load_ir=1 same cycle, next DECODE; else hold.
REQ-018 DECODE: one cycle, all strobes 0; opcodes OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH -> EXECUTE; LOAD, STORE -> ADDR; any other -> TRAP.
REQ-019 EXECUTE: exactly one cycle, then FETCH; load_pc=1 always.
REQ-020 OP/OP-IMM aluop by funct3: 000 add(1) or sub(2) when OP and funct7[5]=1; 111 and(3); 110 or(4); 100 xor(5); 001 sll(6); 101 srl(7) or sra(8) when funct7[5]=1; alumux2_sel 0 for OP, 1 for OP-IMM; regfile_we=1, regfilemux_sel=0, pcmux_sel=0.
REQ-021 SLT/SLTI (010) SHALL output aluop=10+br_lt (combinational on br_lt), cmp_unsigned=0; SLTU/SLTIU (011) same with cmp_unsigned=1.
REQ-022 LUI: aluop=9, alumux2_sel=3, regfile_we=1. AUIPC: aluop=1, alumux1_sel=1, alumux2_sel=3, regfile_we=1.
REQ-023 JAL: aluop=1, alumux1_sel=1, alumux2_sel=3, pcmux_sel=1, regfile_we=1, regfilemux_sel=1. JALR: aluop=0, alumux1_sel=0, alumux2_sel=1, otherwise as JAL.
REQ-024 BRANCH: aluop=1, alumux1_sel=1, alumux2_sel=3, regfile_we=0; cmp_unsigned=1 for funct3 110/111; taken = BEQ br_eq, BNE !br_eq, BLT/BLTU br_lt, BGE/BGEU !br_lt; pcmux_sel=taken; funct3 010/011 -> TRAP instead.
REQ-025 ADDR: aluop=1, alumux1_sel=0, alumux2_sel=1 (load) or 2 (store), load_mar=1; next LOAD or STORE.
REQ-026 LOAD: mem_read=1, mem_size=funct3[1:0]; on mem_resp: regfile_we=1, regfilemux_sel=2, load_pc=1, pcmux_sel=0, next FETCH; else hold.
REQ-027 STORE: mem_write=1, mem_size=funct3[1:0]; on mem_resp: load_pc=1, pcmux_sel=0, next FETCH; else hold.
REQ-028 TRAP: illegal=1, all strobes 0, state held until reset.
REQ-029 mem_resp outside FETCH/LOAD/STORE SHALL be ignored; no timeout on memory waits.
REQ-030 Strobes SHALL be single-cycle per state visit except mem_read/mem_write, held until mem_resp inclusive.

Reset
REQ-031 rst_n low SHALL force FETCH immediately: all strobes 0, illegal=0, aluop=1, mux selects 0, mem_size=2.
REQ-032 Reset asserted mid LOAD/STORE SHALL drop mem_read/mem_write in the same cycle; first edge after deassert starts FETCH.

Verification
REQ-033 ADD x3,x1,x2, mem_resp in 3rd FETCH cycle -> load_ir at cycle 3, DECODE, EXECUTE aluop=1, regfile_we=1, load_pc=1, pcmux_sel=0, then FETCH.
REQ-034 SRAI and SUB -> EXECUTE aluop=8 alumux2_sel=1; aluop=2 alumux2_sel=0.
REQ-035 BGEU with br_lt=0 -> cmp_unsigned=1, pcmux_sel=1; br_lt=1 -> pcmux_sel=0; SLTIU with br_lt=1 -> aluop=11.
REQ-036 LW, mem_resp delayed 5 cycles -> ADDR load_mar=1, mem_read held 5 cycles, mem_size=2, regfile_we+regfilemux_sel=2 on resp cycle only.
REQ-037 ir=32'h0000_0000 -> TRAP, illegal=1 persisting despite mem_resp pulses; rst_n low -> illegal=0, FETCH.
REQ-038 rst_n low during STORE wait -> mem_write=0 same cycle; after release mem_read=1 in FETCH.
